// File: rtl/prefetch_issue_queue_if.sv
// Request bundle between the prefetcher/demand source, the prefetch issue queue and memory.
// master = upstream/memory side, slave = the queue itself.
interface prefetch_issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int CW    = 8
);
    localparam int QCW = $clog2(DEPTH) + 1;

    logic           pf_valid;
    logic [AW-1:0]  pf_addr;
    logic           demand_valid;
    logic [AW-1:0]  demand_addr;
    logic           demand_ack;
    logic           mem_req_valid;
    logic [AW-1:0]  mem_req_addr;
    logic           mem_req_is_pf;
    logic           mem_req_ready;
    logic [QCW-1:0] q_count;
    logic           full;
    logic           empty;
    logic [CW-1:0]  drop_count;

    modport master (
        output pf_valid, pf_addr, demand_valid, demand_addr, mem_req_ready,
        input  demand_ack, mem_req_valid, mem_req_addr, mem_req_is_pf,
        input  q_count, full, empty, drop_count
    );

    modport slave (
        input  pf_valid, pf_addr, demand_valid, demand_addr, mem_req_ready,
        output demand_ack, mem_req_valid, mem_req_addr, mem_req_is_pf,
        output q_count, full, empty, drop_count
    );
endinterface

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: FIFO of prefetch addresses feeding one registered memory request slot,
// demand requests always win the slot. Define PFQ_DEDUP_EN to drop duplicate prefetch addresses.
module prefetch_issue_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    prefetch_issue_queue_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int QCW = PW + 1;

    logic [AW-1:0]  fifo_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [QCW-1:0] count_q, count_d;
    logic           slot_valid_q, slot_valid_d;
    logic [AW-1:0]  slot_addr_q, slot_addr_d;
    logic           slot_is_pf_q, slot_is_pf_d;
    logic [CW-1:0]  drop_q, drop_d;

    logic slot_free_s;
    logic take_demand_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic full_drop_s;
    logic dup_s;
    logic empty_s;
    logic full_s;

`ifdef PFQ_DEDUP_EN
    logic [DEPTH-1:0] entry_hit_s;

    // Duplicate detect: occupied entries (head included even when popping), the slot, the pending demand.
    always_comb begin
        entry_hit_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_hit_s[i] = ({1'b0, (PW'(i) - rd_ptr_q)} < count_q) && (fifo_q[i] == bus.pf_addr);
        end
        dup_s = (|entry_hit_s)
              || (slot_valid_q && (slot_addr_q == bus.pf_addr))
              || (bus.demand_valid && (bus.demand_addr == bus.pf_addr));
    end
`else
    assign dup_s = 1'b0;
`endif

    // Handshake decisions for this cycle; inputs are ignored while in reset.
    always_comb begin
        empty_s       = (count_q == {QCW{1'b0}});
        full_s        = (count_q == QCW'(DEPTH));
        slot_free_s   = !slot_valid_q || bus.mem_req_ready;
        take_demand_s = !rst && slot_free_s && bus.demand_valid;
        pop_s         = !rst && slot_free_s && !bus.demand_valid && !empty_s;
        full_drop_s   = full_s && !pop_s;
        drop_s        = !rst && bus.pf_valid && (full_drop_s || dup_s);
        push_s        = !rst && bus.pf_valid && !full_drop_s && !dup_s;
    end

    // Next-state for pointers, occupancy, drop counter and output slot.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_d       = drop_q;
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_is_pf_d = slot_is_pf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + QCW'(1);
            2'b01:   count_d = count_q - QCW'(1);
            default: count_d = count_q;
        endcase

        if (drop_s && (drop_q != {CW{1'b1}})) begin
            drop_d = drop_q + CW'(1);
        end else begin
            drop_d = drop_q;
        end

        if (take_demand_s) begin
            slot_valid_d = 1'b1;
            slot_addr_d  = bus.demand_addr;
            slot_is_pf_d = 1'b0;
        end else if (pop_s) begin
            slot_valid_d = 1'b1;
            slot_addr_d  = fifo_q[rd_ptr_q];
            slot_is_pf_d = 1'b1;
        end else if (slot_free_s) begin
            slot_valid_d = 1'b0;
        end else begin
            slot_valid_d = slot_valid_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= {QCW{1'b0}};
            drop_q       <= {CW{1'b0}};
            slot_valid_q <= 1'b0;
            slot_addr_q  <= {AW{1'b0}};
            slot_is_pf_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_is_pf_q <= slot_is_pf_d;
        end
    end

    // FIFO storage; occupancy tracking makes stale contents harmless, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= bus.pf_addr;
        end
    end

    assign bus.demand_ack    = take_demand_s;
    assign bus.mem_req_valid = slot_valid_q;
    assign bus.mem_req_addr  = slot_addr_q;
    assign bus.mem_req_is_pf = slot_is_pf_q;
    assign bus.q_count       = count_q;
    assign bus.full          = full_s;
    assign bus.empty         = empty_s;
    assign bus.drop_count    = drop_q;
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue; a scoreboard queue holds the expected issue order.
module tb_prefetch_issue_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 16;
    localparam int CW    = 8;
`ifdef PFQ_DEDUP_EN
    localparam int DUP_Q    = 1;
    localparam int DUP_DROP = 3;
`else
    localparam int DUP_Q    = 2;
    localparam int DUP_DROP = 2;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          is_pf;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    req_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    prefetch_issue_queue_if #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) ifc ();

    prefetch_issue_queue #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    function automatic req_t mk(input logic [AW-1:0] a, input logic pf);
        req_t r;
        r.addr  = a;
        r.is_pf = pf;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare any accepted request against the scoreboard, then advance to the next negedge.
    task automatic tick();
        req_t e;
        #1;
        if (ifc.mem_req_valid === 1'b1 && ifc.mem_req_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_issue: observed=%0h expected=none", ifc.mem_req_addr);
            end else begin
                e = sb.pop_front();
                check("issue_addr", 32'(ifc.mem_req_addr), 32'(e.addr));
                check("issue_is_pf", 32'(ifc.mem_req_is_pf), 32'(e.is_pf));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(ifc.mem_req_valid), 32'd0);
        check({tag, "_addr"},  32'(ifc.mem_req_addr),  32'd0);
        check({tag, "_is_pf"}, 32'(ifc.mem_req_is_pf), 32'd0);
        check({tag, "_qcount"}, 32'(ifc.q_count),      32'd0);
        check({tag, "_empty"}, 32'(ifc.empty),         32'd1);
        check({tag, "_full"},  32'(ifc.full),          32'd0);
        check({tag, "_drop"},  32'(ifc.drop_count),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        ifc.pf_valid      = 1'b0;
        ifc.pf_addr       = 16'h0000;
        ifc.demand_valid  = 1'b0;
        ifc.demand_addr   = 16'h0000;
        ifc.mem_req_ready = 1'b1;
        @(negedge clk);

        // Reset: demand must not be acked while rst is high
        ifc.demand_valid = 1'b1;
        ifc.demand_addr  = 16'h0055;
        #1 check("ack_in_reset", 32'(ifc.demand_ack), 32'd0);
        tick();
        rst              = 1'b0;
        ifc.demand_valid = 1'b0;
        check_reset_state("rst");

        // Single prefetch: issued two cycles after pf_valid
        ifc.pf_valid = 1'b1;
        ifc.pf_addr  = 16'h0040;
        sb.push_back(mk(16'h0040, 1'b1));
        tick();
        ifc.pf_valid = 1'b0;
        check("t1_qcount_n1", 32'(ifc.q_count), 32'd1);
        check("t1_valid_n1", 32'(ifc.mem_req_valid), 32'd0);
        tick();
        check("t1_valid_n2", 32'(ifc.mem_req_valid), 32'd1);
        check("t1_addr_n2", 32'(ifc.mem_req_addr), 32'h0040);
        check("t1_is_pf_n2", 32'(ifc.mem_req_is_pf), 32'd1);
        check("t1_qcount_n2", 32'(ifc.q_count), 32'd0);
        tick();
        check("t1_sb_drained", 32'(sb.size()), 32'd0);
        check("t1_valid_idle", 32'(ifc.mem_req_valid), 32'd0);

        // Demand overtakes queued prefetches
        ifc.pf_valid = 1'b1;
        ifc.pf_addr  = 16'h0100;
        sb.push_back(mk(16'h0100, 1'b1));
        tick();
        ifc.pf_addr      = 16'h0104;
        ifc.demand_valid = 1'b1;
        ifc.demand_addr  = 16'h0200;
        sb.push_front(mk(16'h0200, 1'b0));
        sb.push_back(mk(16'h0104, 1'b1));
        #1 check("t2_demand_ack", 32'(ifc.demand_ack), 32'd1);
        tick();
        ifc.pf_valid     = 1'b0;
        ifc.demand_valid = 1'b0;
        check("t2_slot_addr", 32'(ifc.mem_req_addr), 32'h0200);
        check("t2_slot_is_pf", 32'(ifc.mem_req_is_pf), 32'd0);
        repeat (4) tick();
        check("t2_sb_drained", 32'(sb.size()), 32'd0);
        check("t2_empty", 32'(ifc.empty), 32'd1);

        // Fill with memory stalled: one in slot, DEPTH queued, two dropped
        ifc.mem_req_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            ifc.pf_valid = 1'b1;
            ifc.pf_addr  = 16'h1000 + 16'(i * 4);
            if (i < DEPTH + 1) sb.push_back(mk(16'h1000 + 16'(i * 4), 1'b1));
            tick();
        end
        ifc.pf_valid = 1'b0;
        check("t3_full", 32'(ifc.full), 32'd1);
        check("t3_qcount", 32'(ifc.q_count), 32'(DEPTH));
        check("t3_drop", 32'(ifc.drop_count), 32'd2);
        check("t3_slot_addr", 32'(ifc.mem_req_addr), 32'h1000);
        tick();
        tick();
        check("t3_slot_hold", 32'(ifc.mem_req_addr), 32'h1000);
        check("t3_slot_valid", 32'(ifc.mem_req_valid), 32'd1);

        // Push and pop in the same cycle while full
        ifc.mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifc.pf_valid = 1'b1;
            ifc.pf_addr  = 16'h2000 + 16'(i * 4);
            sb.push_back(mk(16'h2000 + 16'(i * 4), 1'b1));
            tick();
            check("t5_qcount", 32'(ifc.q_count), 32'(DEPTH));
            check("t5_drop", 32'(ifc.drop_count), 32'd2);
        end
        ifc.pf_valid = 1'b0;
        repeat (DEPTH + 3) tick();
        check("t5_sb_drained", 32'(sb.size()), 32'd0);
        check("t5_empty", 32'(ifc.empty), 32'd1);

        // Duplicate address while the first copy is queued
        ifc.mem_req_ready = 1'b0;
        ifc.pf_valid = 1'b1;
        ifc.pf_addr  = 16'h02F0;
        sb.push_back(mk(16'h02F0, 1'b1));
        tick();
        ifc.pf_addr = 16'h0300;
        sb.push_back(mk(16'h0300, 1'b1));
        tick();
        ifc.pf_addr = 16'h0300;
`ifndef PFQ_DEDUP_EN
        sb.push_back(mk(16'h0300, 1'b1));
`endif
        tick();
        ifc.pf_valid = 1'b0;
        check("t4_qcount", 32'(ifc.q_count), 32'(DUP_Q));
        check("t4_drop", 32'(ifc.drop_count), 32'(DUP_DROP));
        ifc.mem_req_ready = 1'b1;
        repeat (5) tick();
        check("t4_sb_drained", 32'(sb.size()), 32'd0);

        // Reset mid-operation discards slot and FIFO; inputs ignored in reset cycle
        ifc.mem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ifc.pf_valid = 1'b1;
            ifc.pf_addr  = 16'h0600 + 16'(i * 4);
            tick();
        end
        ifc.pf_valid = 1'b0;
        check("t6_qcount_pre", 32'(ifc.q_count), 32'd5);
        check("t6_valid_pre", 32'(ifc.mem_req_valid), 32'd1);
        rst              = 1'b1;
        ifc.pf_valid     = 1'b1;
        ifc.pf_addr      = 16'h0777;
        ifc.demand_valid = 1'b1;
        ifc.demand_addr  = 16'h0888;
        #1 check("t6_ack_in_reset", 32'(ifc.demand_ack), 32'd0);
        tick();
        rst              = 1'b0;
        ifc.pf_valid     = 1'b0;
        ifc.demand_valid = 1'b0;
        check_reset_state("t6");
        ifc.mem_req_ready = 1'b1;
        ifc.pf_valid = 1'b1;
        ifc.pf_addr  = 16'h0700;
        sb.push_back(mk(16'h0700, 1'b1));
        tick();
        ifc.pf_valid = 1'b0;
        tick();
        check("t6_post_valid", 32'(ifc.mem_req_valid), 32'd1);
        check("t6_post_addr", 32'(ifc.mem_req_addr), 32'h0700);
        tick();
        check("t6_sb_drained", 32'(sb.size()), 32'd0);
        check("t6_empty", 32'(ifc.empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prefetch_issue_queue.md
# prefetch_issue_queue

Buffers prefetch requests produced by the stride prefetcher (`submitMemRequest` / `requestAddress`) and issues them to the memory request port, always giving CPU demand accesses priority. Sits between the prefetcher and memory. Suppresses duplicate prefetch addresses and drops requests when full, counting each drop. Presents one registered request at a time over a valid/ready handshake.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `AW`, 16: address width.
- `CW`, 8: drop counter width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pf_valid`  in  1  prefetch request strobe, driven by the prefetcher's `submitMemRequest`.
- `pf_addr`  in  AW  prefetch address.
- `demand_valid`  in  1  demand request; upstream holds it and `demand_addr` stable until `demand_ack`.
- `demand_addr`  in  AW  demand address.
- `demand_ack`  out  1  combinational; high in the cycle the demand is loaded into the output slot.
- `mem_req_valid`  out  1  output slot holds a request.
- `mem_req_addr`  out  AW  request address.
- `mem_req_is_pf`  out  1  1 = prefetch, 0 = demand.
- `mem_req_ready`  in  1  memory accepts the slot this cycle.
- `q_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `full`, `empty`  out  1  `q_count==DEPTH` and `q_count==0`, respectively.
- `drop_count`  out  CW  saturating count of discarded prefetches.

## Operation
- **Output slot.** One registered entry {valid, addr, is_pf}.
  - `slot_free = !mem_req_valid || mem_req_ready`.
  - When `slot_free`, the slot loads, in priority order:
    1. demand (`demand_valid`): `is_pf=0`, `demand_ack=1`;
    2. FIFO head (`!empty`): pop, `is_pf=1`;
    3. otherwise `mem_req_valid` goes to 0.
  - When `!slot_free`, the slot holds its contents and `demand_ack=0`.
- **FIFO.** Circular buffer with `DEPTH` entries; read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- **Push rule.** On `pf_valid`, the prefetch is pushed unless it is dropped. Drop conditions:
  - (a) full after accounting for this cycle's pop; a push and pop in the same cycle while full succeeds;
  - (b) duplicate (see Configuration).
- **Drop counter.** Each dropped prefetch increments `drop_count`, saturating at 2^CW−1. A simultaneous full drop and duplicate drop count once.
- **No bypass.** A pushed entry is poppable no earlier than the next cycle.
- **`q_count`.** +1 on push, −1 on pop, unchanged when both occur in the same cycle.

## Timing
- Reset values: `mem_req_valid=0`, `mem_req_addr=0`, `mem_req_is_pf=0`, `q_count=0`, `empty=1`, `full=0`, `drop_count=0`, pointers 0. `demand_ack=0` while `rst` is high.
- Reset mid-operation discards the FIFO contents and any un-accepted slot request. `pf_valid` and `demand_valid` are ignored in the reset cycle.
- Demand latency: `demand_valid` at cycle N with `slot_free` gives `demand_ack` at N and `mem_req_valid` at N+1.
- Prefetch latency: `pf_valid` at N into an empty FIFO with the slot free and no demand gives `mem_req_valid` (`is_pf=1`) at N+2.
- Slot contents are stable while `mem_req_valid && !mem_req_ready`.
- Back-to-back issue is one request per cycle while `mem_req_ready` stays high.
- Starvation: prefetches may wait indefinitely under continuous demand; this is intended.

## Configuration
- `PFQ_DEDUP_EN` defined: an incoming prefetch is dropped as a duplicate if `pf_addr` equals any of:
  - the address of any occupied FIFO entry, including the one being popped this cycle;
  - the slot address while `mem_req_valid`;
  - `demand_addr` while `demand_valid`.
- `PFQ_DEDUP_EN` undefined: no comparators are built; only full drops occur.

## Test plan
- Reset, then `pf_valid` with `pf_addr=0x0040` in one cycle, `mem_req_ready=1` → two cycles later `mem_req_valid=1`, `mem_req_addr=0x0040`, `mem_req_is_pf=1`; `q_count` returns to 0.
- Queue `0x0100` and `0x0104`, then in the same cycle assert `demand_valid` with `demand_addr=0x0200` while the slot is free → `demand_ack=1`; next cycle the slot holds 0x0200 with `is_pf=0`; 0x0100 and 0x0104 follow in order.
- Hold `mem_req_ready=0` and push `DEPTH+3` distinct addresses → `full=1`, `q_count=8`, `drop_count=2` (one entry sits in the slot); slot address unchanged until ready, then in-order drain.
- With `PFQ_DEDUP_EN`, push 0x0300 twice while it is queued → one entry, `drop_count=1`. Without the macro → two entries, `drop_count=0`.
- Push/pop while full, with `mem_req_ready=1` and `pf_valid` held each cycle → push accepted, `q_count` stays 8, no drop.
- Assert `rst` with 5 entries queued and the slot valid → next cycle all outputs at reset values; a later push issues normally.
